// File: rtl/pipe_ctrl_fsm.sv
// pipe_ctrl_fsm: pipeline hazard and data-memory wait controller.
// Combines the load-use stall, taken-branch flush and MEM-stage freeze
// into one set of register enables and flush/bubble controls.
// Optional build macro PIPE_CTRL_STALL_PERF_EN: when defined, stall_cycles
// counts cycles with PcWrite low; otherwise it is tied to zero.
module pipe_ctrl_fsm #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_idex,
  input  logic [4:0]  rd_idex,
  input  logic [4:0]  Rs1_ifid,
  input  logic [4:0]  Rs2_ifid,
  input  logic        branch_taken_ex,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        PcWrite,
  output logic        Ifid_write,
  output logic        Idex_write,
  output logic        Exmem_write,
  output logic        mux_sel,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        mem_wait,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stateT;

  localparam logic [4:0] WAIT_LAST = 5'(WAIT_MAX - 1);

  stateT       r_state;
  logic [4:0]  r_waitCnt;
  logic        r_memTimeout;
  logic [31:0] r_stallCycles;

  logic w_freeze;
  logic w_loadUse;

  // The whole pipeline holds while a data access is outstanding; in
  // MEM_WAIT the freeze drops in the very cycle the memory answers.
  assign w_freeze = ((r_state == RUN) && dmem_req && !dmem_ready) ||
                    ((r_state == MEM_WAIT) && !dmem_ready);

  // A load writing x0 never creates a real dependency.
  assign w_loadUse = MemRead_idex && (rd_idex != 5'd0) &&
                     ((rd_idex == Rs1_ifid) || (rd_idex == Rs2_ifid));

  // Control outputs decoded with priority reset > freeze > branch > load-use.
  // A branch seen during freeze is held upstream, so it simply shows up
  // again on the release cycle and is handled here then.
  always_comb begin
    PcWrite      = 1'b1;
    Ifid_write   = 1'b1;
    Idex_write   = 1'b1;
    Exmem_write  = 1'b1;
    mux_sel      = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (reset) begin
      PcWrite     = 1'b0;
      Ifid_write  = 1'b0;
      Idex_write  = 1'b0;
      Exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (w_freeze) begin
      PcWrite      = 1'b0;
      Ifid_write   = 1'b0;
      Idex_write   = 1'b0;
      Exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_taken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_loadUse) begin
      PcWrite    = 1'b0;
      Ifid_write = 1'b0;
      mux_sel    = 1'b1;
    end
  end

  // Status outputs read as zero while reset is held, even before the edge.
  assign mem_wait    = (r_state == MEM_WAIT) && !reset;
  assign mem_timeout = r_memTimeout && !reset;

  // State machine, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_waitCnt    <= 5'd0;
      r_memTimeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            r_state   <= MEM_WAIT;
            r_waitCnt <= 5'd0;
          end
        end
        MEM_WAIT: begin
          if (r_waitCnt != WAIT_LAST) begin
            r_waitCnt <= r_waitCnt + 5'd1;
          end
          if (dmem_ready) begin
            r_state <= RUN;
          end else if (r_waitCnt == WAIT_LAST) begin
            r_memTimeout <= 1'b1;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_PERF_EN
  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCycles <= 32'd0;
    end else if (!PcWrite && (r_stallCycles != 32'hFFFF_FFFF)) begin
      r_stallCycles <= r_stallCycles + 32'd1;
    end
  end
  assign stall_cycles = reset ? 32'd0 : r_stallCycles;
`else
  assign r_stallCycles = 32'd0;
  assign stall_cycles  = r_stallCycles;
`endif

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// tb_pipe_ctrl_fsm: directed checks of the pipeline control FSM with
// hand-computed expected control vectors. Build with
// PIPE_CTRL_STALL_PERF_EN defined to also check the stall counter.
module tb_pipe_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic        MemRead_idex;
  logic [4:0]  rd_idex;
  logic [4:0]  Rs1_ifid;
  logic [4:0]  Rs2_ifid;
  logic        branch_taken_ex;
  logic        dmem_req;
  logic        dmem_ready;
  logic        PcWrite;
  logic        Ifid_write;
  logic        Idex_write;
  logic        Exmem_write;
  logic        mux_sel;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_bubble;
  logic        mem_wait;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // Bit order: PcWrite Ifid Idex Exmem mux_sel ifid_flush idex_flush bubble mem_wait mem_timeout
  localparam logic [9:0] V_NORMAL  = 10'b1111_0000_00;
  localparam logic [9:0] V_RESET   = 10'b0000_0110_00;
  localparam logic [9:0] V_FRZRUN  = 10'b0000_0001_00;
  localparam logic [9:0] V_FRZWAIT = 10'b0000_0001_10;
  localparam logic [9:0] V_LOADUSE = 10'b0011_1000_00;
  localparam logic [9:0] V_BRANCH  = 10'b1111_0110_00;
  localparam logic [9:0] V_RELBR   = 10'b1111_0110_10;
  localparam logic [9:0] V_RELTO   = 10'b1111_0000_11;
  localparam logic [9:0] V_NORMTO  = 10'b1111_0000_01;
  localparam logic [9:0] V_FRZTO   = 10'b0000_0001_11;

  logic [9:0] ctrlVec;
  assign ctrlVec = {PcWrite, Ifid_write, Idex_write, Exmem_write, mux_sel,
                    ifid_flush, idex_flush, memwb_bubble, mem_wait, mem_timeout};

  pipe_ctrl_fsm #(.WAIT_MAX(16)) dut (
    .clk(clk),
    .reset(reset),
    .MemRead_idex(MemRead_idex),
    .rd_idex(rd_idex),
    .Rs1_ifid(Rs1_ifid),
    .Rs2_ifid(Rs2_ifid),
    .branch_taken_ex(branch_taken_ex),
    .dmem_req(dmem_req),
    .dmem_ready(dmem_ready),
    .PcWrite(PcWrite),
    .Ifid_write(Ifid_write),
    .Idex_write(Idex_write),
    .Exmem_write(Exmem_write),
    .mux_sel(mux_sel),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble),
    .mem_wait(mem_wait),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs just after the rising edge, then let the
  // combinational outputs settle well before the next edge.
  task automatic applyStimulus(input logic rst, input logic memRd, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic br, input logic req, input logic rdy);
    @(posedge clk);
    #1;
    reset           = rst;
    MemRead_idex    = memRd;
    rd_idex         = rd;
    Rs1_ifid        = rs1;
    Rs2_ifid        = rs2;
    branch_taken_ex = br;
    dmem_req        = req;
    dmem_ready      = rdy;
    #3;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b1; MemRead_idex = 1'b0; rd_idex = 5'd0; Rs1_ifid = 5'd0; Rs2_ifid = 5'd0;
    branch_taken_ex = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

    // Reset held for two cycles.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_ctrl", 32'(ctrlVec), 32'(V_RESET));
    checkOutput("reset_stall", stall_cycles, 32'd0);

    // Idle running.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("idle", 32'(ctrlVec), 32'(V_NORMAL));

    // Load-use on Rs2, then normal next cycle.
    applyStimulus(0, 1, 5'd5, 5'd3, 5'd5, 0, 0, 1);
    checkOutput("loaduse_rs2", 32'(ctrlVec), 32'(V_LOADUSE));
    applyStimulus(0, 0, 5'd5, 5'd3, 5'd5, 0, 0, 1);
    checkOutput("after_loaduse", 32'(ctrlVec), 32'(V_NORMAL));

    // Load into x0 never stalls.
    applyStimulus(0, 1, 5'd0, 5'd0, 5'd9, 0, 0, 1);
    checkOutput("x0_load", 32'(ctrlVec), 32'(V_NORMAL));

    // Load-use on Rs1; same registers without MemRead do not stall.
    applyStimulus(0, 1, 5'd7, 5'd7, 5'd2, 0, 0, 1);
    checkOutput("loaduse_rs1", 32'(ctrlVec), 32'(V_LOADUSE));
    applyStimulus(0, 0, 5'd7, 5'd7, 5'd2, 0, 0, 1);
    checkOutput("no_memread", 32'(ctrlVec), 32'(V_NORMAL));

    // Branch overrides load-use.
    applyStimulus(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1);
    checkOutput("branch_over_loaduse", 32'(ctrlVec), 32'(V_BRANCH));

    // Memory wait: ready low three cycles, then high with a pending branch.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("freeze_run", 32'(ctrlVec), 32'(V_FRZRUN));
    applyStimulus(0, 1, 5'd4, 5'd4, 5'd0, 0, 1, 0);
    checkOutput("freeze_over_loaduse", 32'(ctrlVec), 32'(V_FRZWAIT));
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("freeze_over_branch", 32'(ctrlVec), 32'(V_FRZWAIT));
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
    checkOutput("release_branch", 32'(ctrlVec), 32'(V_RELBR));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("back_to_run", 32'(ctrlVec), 32'(V_NORMAL));
`ifdef PIPE_CTRL_STALL_PERF_EN
    checkOutput("stall_count", stall_cycles, 32'd5);
`else
    checkOutput("stall_count", stall_cycles, 32'd0);
`endif

    // Timeout: ready low for 20 cycles (1 in RUN, 19 in MEM_WAIT).
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      if (i == 0)  checkOutput("to_enter", 32'(ctrlVec), 32'(V_FRZRUN));
      if (i == 15) checkOutput("to_not_yet", 32'(ctrlVec), 32'(V_FRZWAIT));
      if (i >= 17) checkOutput("to_set", 32'(ctrlVec), 32'(V_FRZTO));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("to_release", 32'(ctrlVec), 32'(V_RELTO));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("to_sticky", 32'(ctrlVec), 32'(V_NORMTO));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("to_reset_ctrl", 32'(ctrlVec), 32'(V_RESET));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("to_cleared", 32'(ctrlVec), 32'(V_NORMAL));
    checkOutput("stall_cleared", stall_cycles, 32'd0);

    // Reset in the second MEM_WAIT cycle aborts the wait.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("abort_wait1", 32'(ctrlVec), 32'(V_FRZWAIT));
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("abort_reset", 32'(ctrlVec), 32'(V_RESET));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("abort_ctrl", 32'(ctrlVec), 32'(V_NORMAL));
    checkOutput("abort_waitcnt", 32'(dut.r_waitCnt), 32'd0);
    checkOutput("abort_stall", stall_cycles, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
